// File: rtl/cpu_muldiv_pkg.sv
// Shared op codes and FSM states for the multiply/divide unit.
package cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/cpu_div_iter.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step, MSB first.
module cpu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Partial remainder is WIDTH+1 bits wide only transiently; a kept
    // result is always below the divisor, so WIDTH bits of state suffice.
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dvsr      <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cpu_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO; multiply latency is
// counter-driven, divide runs the iterative core then a sign-fix cycle.
module cpu_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);

    localparam int CNT_W = $clog2((WIDTH > 8) ? WIDTH : 8);

    muldiv_state_t state, state_nxt;
    muldiv_op_t    op;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] ma_x, mb_x, prod;

    logic             op_sgn, div_load, div_step;
    logic [WIDTH-1:0] rs_mag, rt_mag, quo, rem, q_fix, r_fix;
    logic             q_neg, r_neg, dz_pend;

    assign op     = muldiv_op_t'(op_i);
    assign op_sgn = is_signed_op(op);
    assign accept = start_i && !abort_i && (state == ST_IDLE);
    assign busy_o = (state != ST_IDLE);

    // Low 2W bits of a 2W x 2W product are exact for both signednesses.
    assign ma_x = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
    assign mb_x = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
    assign prod = ma_x * mb_x;

    assign rs_mag   = (op_sgn && rs_i[WIDTH-1]) ? -rs_i : rs_i;
    assign rt_mag   = (op_sgn && rt_i[WIDTH-1]) ? -rt_i : rt_i;
    assign div_load = accept && ((op == MD_DIV) || (op == MD_DIVU));
    assign div_step = (state == ST_DIV);
    assign q_fix    = q_neg ? -quo : quo;
    assign r_fix    = r_neg ? -rem : rem;

    cpu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if ((op == MD_MULT) || (op == MD_MULTU))    state_nxt = ST_MUL;
                    else if ((op == MD_DIV) || (op == MD_DIVU)) state_nxt = ST_DIV;
                end
            end
            ST_MUL: begin
                if (cnt == '0) begin
                    done_o    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DIV: if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_i && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            done_o    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_o       <= '0;
            lo_o       <= '0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_sgn    <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dz_pend    <= 1'b0;
            div_zero_o <= 1'b0;
        end else if (accept) begin
            div_zero_o <= 1'b0;
            case (op)
                MD_MTHI: hi_o <= rs_i;
                MD_MTLO: lo_o <= rs_i;
                MD_MULT, MD_MULTU: begin
                    mul_a   <= rs_i;
                    mul_b   <= rt_i;
                    mul_sgn <= op_sgn;
                    cnt     <= CNT_W'(MUL_LATENCY - 1);
                end
                MD_DIV, MD_DIVU: begin
                    dz_pend <= (rt_i == '0);
                    q_neg   <= op_sgn && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]) && (rt_i != '0);
                    r_neg   <= op_sgn && rs_i[WIDTH-1];
                    cnt     <= CNT_W'(WIDTH - 1);
                end
                default: ;
            endcase
        end else if (abort_i) begin
            // Flag raised on entry to FIX must not outlive a cancelled divide.
            if (state == ST_FIX) div_zero_o <= 1'b0;
        end else begin
            case (state)
                ST_MUL: begin
                    if (cnt == '0) begin
                        hi_o <= prod[2*WIDTH-1:WIDTH];
                        lo_o <= prod[WIDTH-1:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt == '0) div_zero_o <= dz_pend;
                    else           cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    hi_o <= r_fix;
                    lo_o <= q_fix;
                end
                default: ;
            endcase
        end
    end

endmodule
